// File: rtl/pipe_stage_reg_if.sv
// Payload handshake between a producing stage, the stage register and the consuming stage.
// The producer offers in_data/in_valid every cycle; the register forwards them one edge later as
// out_data/out_valid unless the stall vector holds or bubbles the boundary. There is no back-pressure
// wire: stalling is decided centrally by the stall vector, so valid never waits on a ready.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_held;

  modport master (
    output in_data,
    output in_valid,
    input  out_data,
    input  out_valid,
    input  out_held
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output out_data,
    output out_valid,
    output out_held
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid bit, hold/bubble/flush control, sticky stall-vector
// consistency flag and saturating hold/bubble performance counters.
module pipe_stage_reg #(
  parameter int                  DATA_W     = 64,
  parameter int                  STALL_W    = 6,
  parameter int                  STAGE      = 1,
  parameter logic [DATA_W-1:0]   RESET_VAL  = 64'h0000_3000_0000_3000,
  parameter logic [DATA_W-1:0]   BUBBLE_VAL = '0,
  parameter int                  CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_stage_reg_if.slave    bus,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               perf_clr,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic               err_stall
);

  generate
    if (DATA_W < 1) begin : g_bad_data_w
      $error("pipe_stage_reg: DATA_W must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("pipe_stage_reg: CNT_W must be >= 1");
    end
    if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE must satisfy 0 <= STAGE <= STALL_W-2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_HOLD    = 2'd1,
    ACT_BUBBLE  = 2'd2,
    ACT_FLUSH   = 2'd3
  } action_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic s_stall;
  logic n_stall;
  logic illegal_stall;
  logic unused_stall;

  assign s_stall       = stall[STAGE];
  assign n_stall       = stall[STAGE+1];
  assign illegal_stall = !s_stall && n_stall;
  // Only two bits of the shared vector matter at this boundary.
  assign unused_stall  = ^stall;

  action_e           action;
  logic [DATA_W-1:0] data_d;
  logic              valid_d;
  logic              held_d;
  logic [CNT_W-1:0]  hold_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_d;
  logic              err_stall_d;

  always_comb begin
    action = ACT_ADVANCE;
    if (flush)                   action = ACT_FLUSH;
    else if (s_stall && !n_stall) action = ACT_BUBBLE;
    else if (s_stall && n_stall)  action = ACT_HOLD;
  end

  always_comb begin
    data_d  = bus.out_data;
    valid_d = bus.out_valid;
    held_d  = 1'b0;
    unique case (action)
      ACT_FLUSH, ACT_BUBBLE: begin
        data_d  = BUBBLE_VAL;
        valid_d = 1'b0;
      end
      ACT_HOLD: held_d = 1'b1;
      default: begin
        data_d  = bus.in_data;
        valid_d = bus.in_valid;
      end
    endcase
  end

  // A clear wins over any increment landing in the same cycle; the datapath is unaffected by it.
  always_comb begin
    hold_cnt_d   = hold_cnt;
    bubble_cnt_d = bubble_cnt;
    err_stall_d  = err_stall | illegal_stall;
    if (perf_clr) begin
      hold_cnt_d   = '0;
      bubble_cnt_d = '0;
      err_stall_d  = 1'b0;
    end else begin
      if (action == ACT_HOLD && hold_cnt != CNT_MAX)
        hold_cnt_d = hold_cnt + 1'b1;
      if (action == ACT_BUBBLE && bubble_cnt != CNT_MAX)
        bubble_cnt_d = bubble_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data  <= RESET_VAL;
      bus.out_valid <= 1'b0;
      bus.out_held  <= 1'b0;
      hold_cnt      <= '0;
      bubble_cnt    <= '0;
      err_stall     <= 1'b0;
    end else begin
      bus.out_data  <= data_d;
      bus.out_valid <= valid_d;
      bus.out_held  <= held_d;
      hold_cnt      <= hold_cnt_d;
      bubble_cnt    <= bubble_cnt_d;
      err_stall     <= err_stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, advance, hold, bubble, flush, saturation/clear,
// illegal stall vector and asynchronous reset in the middle of a stall.
module tb_pipe_stage_reg;

  localparam int               DATA_W    = 64;
  localparam int               STALL_W   = 6;
  localparam int               CNT_W     = 4;
  localparam logic [63:0]      RESET_VAL = 64'h0000_3000_0000_3000;

  logic               clk;
  logic               rst_n;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               perf_clr;
  logic [CNT_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]   bubble_cnt;
  logic               err_stall;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg_if #(.DATA_W(DATA_W)) bus ();

  pipe_stage_reg #(
    .DATA_W    (DATA_W),
    .STALL_W   (STALL_W),
    .STAGE     (1),
    .RESET_VAL (RESET_VAL),
    .BUBBLE_VAL('0),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .stall     (stall),
    .flush     (flush),
    .perf_clr  (perf_clr),
    .hold_cnt  (hold_cnt),
    .bubble_cnt(bubble_cnt),
    .err_stall (err_stall)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: advance one rising edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [63:0] data, input logic valid,
                            input logic held);
    check({tag, ".data"}, bus.out_data, data);
    check({tag, ".valid"}, {63'd0, bus.out_valid}, {63'd0, valid});
    check({tag, ".held"}, {63'd0, bus.out_held}, {63'd0, held});
  endtask

  task automatic check_perf(input string tag, input logic [CNT_W-1:0] hc,
                            input logic [CNT_W-1:0] bc, input logic err);
    check({tag, ".hold_cnt"}, {60'd0, hold_cnt}, {60'd0, hc});
    check({tag, ".bubble_cnt"}, {60'd0, bubble_cnt}, {60'd0, bc});
    check({tag, ".err_stall"}, {63'd0, err_stall}, {63'd0, err});
  endtask

  initial begin
    rst_n       = 1'b1;
    stall       = '0;
    flush       = 1'b0;
    perf_clr    = 1'b0;
    bus.in_data = 64'h0;
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_outs("reset", RESET_VAL, 1'b0, 1'b0);
    check_perf("reset", 4'd0, 4'd0, 1'b0);

    step();
    check_outs("reset_edge", RESET_VAL, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Advance: one-cycle latency, no combinational path before the edge
    bus.in_data  = 64'h0000_3004_0000_3008;
    bus.in_valid = 1'b1;
    #1;
    check("no_comb_path", bus.out_data, RESET_VAL);
    step();
    check_outs("advance", 64'h0000_3004_0000_3008, 1'b1, 1'b0);

    // Hold for 3 cycles with changing input
    bus.in_data = 64'hA;
    step();
    check_outs("load_a", 64'hA, 1'b1, 1'b0);
    stall = 6'b000110;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = {$urandom, $urandom} | 64'h100;
      step();
      check_outs("hold_a", 64'hA, 1'b1, 1'b1);
    end
    check_perf("hold_a", 4'd3, 4'd0, 1'b0);

    // Two consecutive bubbles
    stall = 6'b000010;
    step();
    check_outs("bubble1", 64'h0, 1'b0, 1'b0);
    step();
    check_outs("bubble2", 64'h0, 1'b0, 1'b0);
    check_perf("bubble", 4'd3, 4'd2, 1'b0);

    stall       = '0;
    bus.in_data = 64'hB;
    step();
    check_outs("advance_b", 64'hB, 1'b1, 1'b0);

    // Flush wins over a hold and the hold is not counted
    bus.in_data = 64'hC;
    step();
    check_outs("load_c", 64'hC, 1'b1, 1'b0);
    stall = 6'b000110;
    step();
    check_outs("hold_c", 64'hC, 1'b1, 1'b1);
    check_perf("hold_c", 4'd4, 4'd2, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_outs("flush", 64'h0, 1'b0, 1'b0);
    check_perf("flush", 4'd4, 4'd2, 1'b0);

    // Saturation: 11 more holds reach 15, further holds stay at 15
    for (int i = 0; i < 11; i++) step();
    check_perf("sat_reach", 4'hF, 4'd2, 1'b0);
    for (int i = 0; i < 9; i++) step();
    check_perf("sat_stay", 4'hF, 4'd2, 1'b0);
    check_outs("sat_hold", 64'h0, 1'b0, 1'b1);

    // Clear beats a concurrent hold increment
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    check_perf("clear", 4'd0, 4'd0, 1'b0);
    check_outs("clear_hold", 64'h0, 1'b0, 1'b1);

    // Illegal stall combination advances and sets a sticky flag
    stall        = 6'b000100;
    bus.in_data  = 64'hD;
    bus.in_valid = 1'b1;
    step();
    check_outs("illegal", 64'hD, 1'b1, 1'b0);
    check_perf("illegal", 4'd0, 4'd0, 1'b1);
    stall       = '0;
    bus.in_data = 64'hE;
    step();
    check_outs("after_illegal", 64'hE, 1'b1, 1'b0);
    check_perf("sticky", 4'd0, 4'd0, 1'b1);
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    check_perf("err_clear", 4'd0, 4'd0, 1'b0);

    // Asynchronous reset in the middle of a stall
    bus.in_data = 64'h55;
    step();
    stall = 6'b000110;
    step();
    check_outs("pre_reset_hold", 64'h55, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_outs("mid_reset", RESET_VAL, 1'b0, 1'b0);
    check_perf("mid_reset", 4'd0, 4'd0, 1'b0);
    flush = 1'b1;
    step();
    check_outs("reset_dominates", RESET_VAL, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
